// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Iteration counter must be able to count up to WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_unit.sv
// Ripple adder/subtractor used for the divider's trial subtraction (sub=1 computes a-b).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module addsub_unit #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  // Two's-complement subtract via inverted b plus carry-in; cout=1 means a>=b when subtracting.
  always_comb begin
    full = {1'b0, a} + {1'b0, (b ^ {W{sub}})} + {{W{1'b0}}, sub};
  end

  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per cycle; optional signed mode via DIVIDER_SIGNED_EN.
// Latency: start accepted at edge N -> done in cycle after edge N+WIDTH+1 (N+1 for divide by zero).
// Backpressure: accepts start only when idle (busy low); start while busy is dropped, never queued.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem_q;    // partial remainder
  logic [WIDTH-1:0] dq_q;     // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q;    // captured divisor (magnitude)
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic             unused_trial_msb;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dq_nxt;
  logic             last_iter;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fin, r_fin;

  assign dvs_zero  = (divisor == '0);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // One restoring step: shift {rem, dq} left, trial-subtract the divisor.
  assign shifted = {rem_q, dq_q[WIDTH-1]};

  addsub_unit #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a    (shifted),
    .b    ({1'b0, dvs_q}),
    .sub  (1'b1),
    .sum  (trial),
    .cout (trial_ok)
  );

  // A non-negative difference always fits in WIDTH bits since it is below the divisor.
  assign unused_trial_msb = trial[WIDTH];
  assign rem_nxt = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dq_nxt  = {dq_q[WIDTH-2:0], trial_ok};

`ifdef DIVIDER_SIGNED_EN
  logic q_neg_q, r_neg_q;

  // Core runs on magnitudes; most-negative maps to its own bit pattern, read as unsigned.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_fin   = q_neg_q ? -dq_nxt  : dq_nxt;
  assign r_fin   = r_neg_q ? -rem_nxt : rem_nxt;

  // Result signs captured at acceptance and applied when results are loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (state == IDLE && start && !dvs_zero) begin
      q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_q <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fin   = dq_nxt;
  assign r_fin   = rem_nxt;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and busy flag.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = dvs_zero ? FINISH : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result load on FINISH entry; done trails FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      dq_q        <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            if (dvs_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem_q <= '0;
              dq_q  <= dvd_mag;
              dvs_q <= dvs_mag;
              cnt_q <= '0;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          dq_q  <= dq_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            quotient    <= q_fin;
            remainder   <= r_fin;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: stimulus pushes model results, monitor pops on done.
// Latency: expected done edge is tracked per transaction and compared.
// Backpressure: operations are issued only while busy is low.
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int edges = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sbq[$];

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    int sa, sb;
    e.due = due;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
`else
      sa = int'(a);
      sb = int'(b);
`endif
      e.q  = W'(sa / sb);
      e.r  = W'(sa % sb);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the first falling edge with busy low.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_wait_timeout", 1, 0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sbq.push_back(model(a, b, edges + 1 + ((b == '0) ? 1 : W + 1)));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", div_by_zero, e.dz);
          check("done_edge", edges, e.due);
          check("busy_low_with_done", busy, 0);
        end
      end else if (sbq.size() > 0 && edges > sbq[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_done: got no done by edge %0d expected done at edge %0d", edges, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);

    // First start on the first rising edge after release.
    rst_n = 1'b1;
    issue(4'd7, 4'd2);
    issue(4'd13, 4'd0);

    // Back-to-back: restart in the idle cycle that carries done.
    issue(4'd15, 4'd1);
    wait_idle();
    check("b2b_done_in_idle_cycle", done, 1);
    issue(4'd2, 4'd5);

    // Start during CALC must be ignored.
    issue(4'd9, 4'd2);
    dividend = 4'd15;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_quotient", quotient, model(4'd9, 4'd2, 0).q);
    check("hold_remainder", remainder, model(4'd9, 4'd2, 0).r);

    // Reset in the middle of CALC: abandon, outputs clear at once.
    issue(4'd14, 4'd3);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    sbq.delete();
    repeat (W + 3) begin
      @(negedge clk);
      check("no_done_in_reset", done, 0);
    end
    rst_n = 1'b1;
    issue(4'd10, 4'd3);

`ifdef DIVIDER_SIGNED_EN
    issue(4'b1001, 4'd2);
    issue(4'b1000, 4'b1111);
    issue(4'b0111, 4'b1110);
`endif

    // Randomized operands, roughly one in eight with a zero divisor.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
      issue(a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sbq.size());
    end
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
